// File: rtl/rpspmc_pkg.sv
// Shared types and sizing helpers for the RPSPMC sample-rate converters.
package rpspmc_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  // Accumulator holds sample<<INTERP_L plus one guard bit for the ramp sum.
  function automatic int acc_width(input int sample_width, input int interp_l);
    return sample_width + interp_l + 1;
  endfunction

endpackage

// File: rtl/interp_step_acc.sv
// Ramp accumulator for the interpolator: holds acc/delta/step count and
// produces the output slice plus the end-of-segment indication.
module interp_step_acc
  import rpspmc_pkg::*;
#(
  parameter int SAXIS_TDATA_WIDTH = 32,
  parameter int MAXIS_TDATA_WIDTH = 32,
  parameter int INTERP_L          = 6
) (
  input  logic                                a_clk,
  input  logic                                reset,
  input  logic                                load_first,
  input  logic signed [SAXIS_TDATA_WIDTH-1:0] first_sample,
  input  logic                                load_seg,
  input  logic signed [SAXIS_TDATA_WIDTH-1:0] seg_next,
  input  logic signed [SAXIS_TDATA_WIDTH-1:0] seg_cur,
  input  logic                                step,
  input  logic                                halt,
  output logic                                last_step,
  output logic signed [MAXIS_TDATA_WIDTH-1:0] tdata
);

  localparam int AW = acc_width(SAXIS_TDATA_WIDTH, INTERP_L);
  localparam int DW = SAXIS_TDATA_WIDTH + 1;

  logic signed [AW-1:0]       acc;
  logic signed [DW-1:0]       delta;
  logic        [INTERP_L-1:0] k;

  logic signed [DW-1:0] seg_delta;
  logic signed [AW-1:0] acc_first;
  logic signed [AW-1:0] acc_next;

  assign seg_delta = DW'(seg_next) - DW'(seg_cur);
  assign acc_first = AW'(first_sample) <<< INTERP_L;
  assign acc_next  = acc + AW'(delta);

  // Later assignments win: a segment reload in the same cycle as the final
  // step restarts k and replaces delta while acc still takes that step.
  always_ff @(posedge a_clk) begin
    if (reset) begin
      acc   <= '0;
      delta <= '0;
      k     <= '0;
    end else begin
      if (load_first) begin
        acc   <= acc_first;
        delta <= '0;
        k     <= '0;
      end
      if (step) begin
        acc <= acc_next;
        k   <= k + INTERP_L'(1);
      end
      if (load_seg) begin
        delta <= seg_delta;
        k     <= '0;
      end
      if (halt) begin
        delta <= '0;
      end
    end
  end

  assign last_step = &k;
  assign tdata     = acc[INTERP_L+SAXIS_TDATA_WIDTH-1 -: MAXIS_TDATA_WIDTH];

endmodule

// File: rtl/axis_fir_interp.sv
// Linear interpolator: expands each low-rate AXIS sample into 2^INTERP_L
// ramp steps paced by next_dv, with a one-entry look-ahead input buffer.
//
// state | meaning
// EMPTY | no sample seen since reset; output invalid
// HOLD  | output parked at x_cur, waiting for a buffered sample
// RUN   | stepping acc from previous sample toward x_cur on each next_dv
module axis_fir_interp
  import rpspmc_pkg::*;
#(
  parameter int SAXIS_TDATA_WIDTH = 32,
  parameter int MAXIS_TDATA_WIDTH = 32,
  parameter int INTERP_L          = 6
) (
  input  logic                                a_clk,
  input  logic                                reset,
  input  logic                                next_dv,
  input  logic signed [SAXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                                S_AXIS_tvalid,
  output logic                                S_AXIS_tready,
  output logic signed [MAXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                                M_AXIS_tvalid,
  output logic                                underrun
);

  state_t state, state_nxt;

  logic signed [SAXIS_TDATA_WIDTH-1:0] x_cur;
  logic signed [SAXIS_TDATA_WIDTH-1:0] next_buf;
  logic                                next_full;
  logic                                out_valid;
  logic                                underrun_q;

  logic accept;
  logic load_first;
  logic load_seg;
  logic step;
  logic halt;
  logic consume;
  logic set_underrun;
  logic last_step;

  assign S_AXIS_tready = !next_full;
  assign accept        = S_AXIS_tvalid && !next_full;
  assign M_AXIS_tvalid = out_valid;
  assign underrun      = underrun_q;

  always_comb begin
    state_nxt    = state;
    load_first   = 1'b0;
    load_seg     = 1'b0;
    step         = 1'b0;
    halt         = 1'b0;
    consume      = 1'b0;
    set_underrun = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_first = 1'b1;
          state_nxt  = HOLD;
        end
      end
      HOLD: begin
        if (next_dv && next_full) begin
          load_seg  = 1'b1;
          consume   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (next_dv) begin
          step = 1'b1;
          if (last_step) begin
            if (next_full) begin
              load_seg = 1'b1;
              consume  = 1'b1;
            end else begin
              halt         = 1'b1;
              set_underrun = 1'b1;
              state_nxt    = HOLD;
            end
          end
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // The very first sample goes straight to x_cur; later ones wait in next_buf.
  always_ff @(posedge a_clk) begin
    if (reset) begin
      state      <= EMPTY;
      x_cur      <= '0;
      next_buf   <= '0;
      next_full  <= 1'b0;
      out_valid  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_first) begin
        x_cur     <= S_AXIS_tdata;
        out_valid <= 1'b1;
      end
      if (accept && state != EMPTY) begin
        next_buf  <= S_AXIS_tdata;
        next_full <= 1'b1;
      end
      if (consume) begin
        x_cur     <= next_buf;
        next_full <= 1'b0;
      end
      if (set_underrun) begin
        underrun_q <= 1'b1;
      end
    end
  end

  interp_step_acc #(
    .SAXIS_TDATA_WIDTH(SAXIS_TDATA_WIDTH),
    .MAXIS_TDATA_WIDTH(MAXIS_TDATA_WIDTH),
    .INTERP_L         (INTERP_L)
  ) u_step_acc (
    .a_clk       (a_clk),
    .reset       (reset),
    .load_first  (load_first),
    .first_sample(S_AXIS_tdata),
    .load_seg    (load_seg),
    .seg_next    (next_buf),
    .seg_cur     (x_cur),
    .step        (step),
    .halt        (halt),
    .last_step   (last_step),
    .tdata       (M_AXIS_tdata)
  );

endmodule

// File: tb/tb_axis_fir_interp.sv
// Directed bench for axis_fir_interp: one instance with INTERP_L=2 for the
// ramp/handshake/reset cases and one with INTERP_L=6 for full-scale swings.
module tb_axis_fir_interp;

  logic               a_clk;
  logic               reset;
  logic               next_dv;
  logic signed [15:0] s_tdata;
  logic               s_tvalid;

  logic               tready_a, tready_b;
  logic signed [15:0] tdata_a, tdata_b;
  logic               tvalid_a, tvalid_b;
  logic               underrun_a, underrun_b;

  int errors = 0;
  int checks = 0;

  axis_fir_interp #(
    .SAXIS_TDATA_WIDTH(16), .MAXIS_TDATA_WIDTH(16), .INTERP_L(2)
  ) dut_a (
    .a_clk(a_clk), .reset(reset), .next_dv(next_dv),
    .S_AXIS_tdata(s_tdata), .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(tready_a),
    .M_AXIS_tdata(tdata_a), .M_AXIS_tvalid(tvalid_a), .underrun(underrun_a)
  );

  axis_fir_interp #(
    .SAXIS_TDATA_WIDTH(16), .MAXIS_TDATA_WIDTH(16), .INTERP_L(6)
  ) dut_b (
    .a_clk(a_clk), .reset(reset), .next_dv(next_dv),
    .S_AXIS_tdata(s_tdata), .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(tready_b),
    .M_AXIS_tdata(tdata_b), .M_AXIS_tvalid(tvalid_b), .underrun(underrun_b)
  );

  initial a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  // Inputs are applied before an edge; expectations describe outputs after it.
  typedef struct {
    logic     rst;
    logic     tv;
    int       d;
    logic     dv;
    int       e_data;
    logic     e_mvalid;
    logic     e_tready;
    logic     e_ur;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic tv, input int d, input logic dv,
                     input int e_data, input logic e_mvalid, input logic e_tready,
                     input logic e_ur);
    vec_t v;
    v.rst = rst; v.tv = tv; v.d = d; v.dv = dv;
    v.e_data = e_data; v.e_mvalid = e_mvalid; v.e_tready = e_tready; v.e_ur = e_ur;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d want %0d", nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx, input bit sel_b);
    reset    = v.rst;
    s_tvalid = v.tv;
    s_tdata  = 16'(v.d);
    next_dv  = v.dv;
    @(posedge a_clk);
    #1;
    if (!sel_b) begin
      chk("tdata_a",    idx, int'(tdata_a),   v.e_data);
      chk("tvalid_a",   idx, int'(tvalid_a),  int'(v.e_mvalid));
      chk("tready_a",   idx, int'(tready_a),  int'(v.e_tready));
      chk("underrun_a", idx, int'(underrun_a), int'(v.e_ur));
    end else begin
      chk("tdata_b",    idx, int'(tdata_b),   v.e_data);
      chk("tvalid_b",   idx, int'(tvalid_b),  int'(v.e_mvalid));
      chk("tready_b",   idx, int'(tready_b),  int'(v.e_tready));
      chk("underrun_b", idx, int'(underrun_b), int'(v.e_ur));
    end
  endtask

  initial begin
    vec_t v;
    int   exp_v;

    reset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; next_dv = 1'b0;

    // rst tv  d     dv  data  mv tr ur
    // ramp up 0 -> 400
    add(1, 0,    0, 1,    0, 0, 1, 0);
    add(0, 1,    0, 1,    0, 1, 1, 0);
    add(0, 1,  400, 1,    0, 1, 0, 0);
    add(0, 0,    0, 1,    0, 1, 1, 0);
    add(0, 0,    0, 1,  100, 1, 1, 0);
    add(0, 0,    0, 1,  200, 1, 1, 0);
    add(0, 0,    0, 1,  300, 1, 1, 0);
    add(0, 0,    0, 1,  400, 1, 1, 1);
    add(0, 0,    0, 1,  400, 1, 1, 1);
    // ramp down across zero
    add(0, 1, -400, 1,  400, 1, 0, 1);
    add(0, 0,    0, 1,  400, 1, 1, 1);
    add(0, 0,    0, 1,  200, 1, 1, 1);
    add(0, 0,    0, 1,    0, 1, 1, 1);
    add(0, 0,    0, 1, -200, 1, 1, 1);
    add(0, 0,    0, 1, -400, 1, 1, 1);
    add(0, 0,    0, 1, -400, 1, 1, 1);
    // back-to-back 0, 400, 800 with tvalid held high
    add(1, 0,    0, 1,    0, 0, 1, 0);
    add(0, 1,    0, 1,    0, 1, 1, 0);
    add(0, 1,  400, 1,    0, 1, 0, 0);
    add(0, 1,  800, 1,    0, 1, 1, 0);
    add(0, 1,  800, 1,  100, 1, 0, 0);
    add(0, 1,  800, 1,  200, 1, 0, 0);
    add(0, 1,  800, 1,  300, 1, 0, 0);
    add(0, 1,  800, 1,  400, 1, 1, 0);
    add(0, 0,    0, 1,  500, 1, 1, 0);
    add(0, 0,    0, 1,  600, 1, 1, 0);
    add(0, 0,    0, 1,  700, 1, 1, 0);
    add(0, 0,    0, 1,  800, 1, 1, 1);
    add(0, 0,    0, 1,  800, 1, 1, 1);
    // reset mid-RUN with a buffered sample, then restart at 50
    add(1, 0,    0, 1,    0, 0, 1, 0);
    add(0, 1,    0, 1,    0, 1, 1, 0);
    add(0, 1,  400, 1,    0, 1, 0, 0);
    add(0, 0,    0, 1,    0, 1, 1, 0);
    add(0, 1,  999, 1,  100, 1, 0, 0);
    add(0, 0,    0, 1,  200, 1, 0, 0);
    add(1, 0,    0, 1,    0, 0, 1, 0);
    add(0, 1,   50, 0,   50, 1, 1, 0);
    add(0, 0,    0, 1,   50, 1, 1, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i, 1'b0);

    // next_dv one cycle in four during a 0 -> 400 segment
    v = '{rst:1, tv:0, d:0,   dv:1, e_data:0, e_mvalid:0, e_tready:1, e_ur:0}; apply(v, 100, 1'b0);
    v = '{rst:0, tv:1, d:0,   dv:1, e_data:0, e_mvalid:1, e_tready:1, e_ur:0}; apply(v, 101, 1'b0);
    v = '{rst:0, tv:1, d:400, dv:0, e_data:0, e_mvalid:1, e_tready:0, e_ur:0}; apply(v, 102, 1'b0);
    v = '{rst:0, tv:0, d:0,   dv:1, e_data:0, e_mvalid:1, e_tready:1, e_ur:0}; apply(v, 103, 1'b0);
    for (int s = 1; s <= 4; s++) begin
      for (int j = 0; j < 3; j++) begin
        v = '{rst:0, tv:0, d:0, dv:0, e_data:100*(s-1), e_mvalid:1, e_tready:1, e_ur:0};
        apply(v, 110 + 4*s + j, 1'b0);
      end
      v = '{rst:0, tv:0, d:0, dv:1, e_data:100*s, e_mvalid:1, e_tready:1, e_ur:logic'(s == 4)};
      apply(v, 113 + 4*s, 1'b0);
    end

    // full-scale swing on the INTERP_L=6 instance
    v = '{rst:1, tv:0, d:0,      dv:1, e_data:0,     e_mvalid:0, e_tready:1, e_ur:0}; apply(v, 200, 1'b1);
    v = '{rst:0, tv:1, d:32767,  dv:1, e_data:32767, e_mvalid:1, e_tready:1, e_ur:0}; apply(v, 201, 1'b1);
    v = '{rst:0, tv:1, d:-32768, dv:1, e_data:32767, e_mvalid:1, e_tready:0, e_ur:0}; apply(v, 202, 1'b1);
    v = '{rst:0, tv:0, d:0,      dv:1, e_data:32767, e_mvalid:1, e_tready:1, e_ur:0}; apply(v, 203, 1'b1);
    for (int i = 1; i <= 64; i++) begin
      exp_v = (32767 * 64 - i * 65535) >>> 6;
      v = '{rst:0, tv:0, d:0, dv:1, e_data:exp_v, e_mvalid:1, e_tready:1, e_ur:logic'(i == 64)};
      apply(v, 300 + i, 1'b1);
    end
    v = '{rst:0, tv:0, d:0, dv:1, e_data:-32768, e_mvalid:1, e_tready:1, e_ur:1}; apply(v, 400, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
